// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register, one instance per stage boundary
// (F/D, D/E, E/M, M/W). Each instance carries an opaque payload, the
// destination register, RegWrite, a Tnew countdown and a valid bit. It also
// answers NQ hazard queries so the hazard unit can decide, per source operand,
// whether to stall issue or forward from this stage.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (clears every field)
//   stall        hold current contents
//   flush        load an all-zero bubble (beats stall)
//   in_valid     upstream slot holds a real instruction
//   in_data      upstream payload (DATA_W bits)
//   in_a3        upstream destination register
//   in_regwrite  upstream writes the register file
//   in_tnew      upstream Tnew (cycles until result ready)
//   out_valid    registered valid
//   out_data     registered payload
//   out_a3       registered destination register
//   out_regwrite registered RegWrite, already gated by valid and a3 != 0
//   out_tnew     registered Tnew
//   q_addr       query register numbers, channel i at [5i+4:5i]
//   q_tuse       query Tuse values, channel i at [TNEW_W*i +: TNEW_W]
//   q_hit        this stage produces q_addr[i]
//   q_stall      hit and the value is not ready in time
//   q_fwd        hit and the value is ready now
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W   = 64,
   parameter int TNEW_W   = 2,
   parameter int TNEW_DEC = 1,
   parameter int NQ       = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [4:0]            in_a3,
   input  logic                  in_regwrite,
   input  logic [TNEW_W-1:0]     in_tnew,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [4:0]            out_a3,
   output logic                  out_regwrite,
   output logic [TNEW_W-1:0]     out_tnew,
   input  logic [5*NQ-1:0]       q_addr,
   input  logic [TNEW_W*NQ-1:0]  q_tuse,
   output logic [NQ-1:0]         q_hit,
   output logic [NQ-1:0]         q_stall,
   output logic [NQ-1:0]         q_fwd
);

   // Declaration initialisers give clean contents before the first reset.
   logic                r_valid    = 1'b0;
   logic [DATA_W-1:0]   r_data     = '0;
   logic [4:0]          r_a3       = 5'd0;
   logic                r_regwrite = 1'b0;
   logic [TNEW_W-1:0]   r_tnew     = '0;

   logic                w_regwrite_in;
   logic [TNEW_W-1:0]   w_tnew_in;

   // Tnew as seen one stage further down: count down, but never wrap below 0.
   function automatic logic [TNEW_W-1:0] f_tnew_next(input logic [TNEW_W-1:0] t);
      if (TNEW_DEC != 0) begin
         if (t == '0)
            return '0;
         else
            return t - TNEW_W'(1);
      end else begin
         return t;
      end
   endfunction

   // A write to $0 or from an invalid slot never counts as a producer.
   assign w_regwrite_in = in_regwrite & in_valid & (in_a3 != 5'd0);
   assign w_tnew_in     = f_tnew_next(in_tnew);

   // ---- stage register: reset/flush > stall > load ----
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_a3       <= 5'd0;
         r_regwrite <= 1'b0;
         r_tnew     <= '0;
      end else if (!stall) begin
         r_valid    <= in_valid;
         r_data     <= in_data;
         r_a3       <= in_a3;
         r_regwrite <= w_regwrite_in;
         r_tnew     <= w_tnew_in;
      end
   end

   assign out_valid    = r_valid;
   assign out_data     = r_data;
   assign out_a3       = r_a3;
   assign out_regwrite = r_regwrite;
   assign out_tnew     = r_tnew;

   // ---- hazard queries: driven from registered state only, so chained
   //      instances never form a combinational loop ----
   for (genvar gi = 0; gi < NQ; gi++) begin : g_query
      logic [4:0]        w_addr;
      logic [TNEW_W-1:0] w_tuse;
      logic              w_hit;

      assign w_addr = q_addr[5*gi +: 5];
      assign w_tuse = q_tuse[TNEW_W*gi +: TNEW_W];
      assign w_hit  = r_valid & r_regwrite & (r_a3 == w_addr) & (w_addr != 5'd0);

      assign q_hit[gi]   = w_hit;
      assign q_stall[gi] = w_hit & (r_tnew > w_tuse);
      assign q_fwd[gi]   = w_hit & (r_tnew == '0);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg with default parameters
// (DATA_W=64, TNEW_W=2, TNEW_DEC=1, NQ=2). A vector table covers load,
// reset, stall, flush and the $0 RegWrite filter; hand sequences cover the
// hazard-query channels.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic [4:0]  in_a3;
   logic        in_regwrite;
   logic [1:0]  in_tnew;
   logic        out_valid;
   logic [63:0] out_data;
   logic [4:0]  out_a3;
   logic        out_regwrite;
   logic [1:0]  out_tnew;
   logic [9:0]  q_addr;
   logic [3:0]  q_tuse;
   logic [1:0]  q_hit, q_stall, q_fwd;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_a3        (in_a3),
      .in_regwrite  (in_regwrite),
      .in_tnew      (in_tnew),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_a3       (out_a3),
      .out_regwrite (out_regwrite),
      .out_tnew     (out_tnew),
      .q_addr       (q_addr),
      .q_tuse       (q_tuse),
      .q_hit        (q_hit),
      .q_stall      (q_stall),
      .q_fwd        (q_fwd)
   );

   typedef struct {
      string       name;
      logic        rst, stl, fls, vld;
      logic [63:0] data;
      logic [4:0]  a3;
      logic        rw;
      logic [1:0]  tnew;
      logic        e_vld;
      logic [63:0] e_data;
      logic [4:0]  e_a3;
      logic        e_rw;
      logic [1:0]  e_tnew;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input string nm,
                               input logic r, s, f, v,
                               input logic [63:0] d, input logic [4:0] a,
                               input logic w, input logic [1:0] t,
                               input logic ev, input logic [63:0] ed,
                               input logic [4:0] ea, input logic ew,
                               input logic [1:0] et);
      vec_t x;
      x.name = nm; x.rst = r; x.stl = s; x.fls = f; x.vld = v;
      x.data = d; x.a3 = a; x.rw = w; x.tnew = t;
      x.e_vld = ev; x.e_data = ed; x.e_a3 = ea; x.e_rw = ew; x.e_tnew = et;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, s, f, v, input logic [63:0] d,
                        input logic [4:0] a, input logic w, input logic [1:0] t);
      reset = r; stall = s; flush = f; in_valid = v;
      in_data = d; in_a3 = a; in_regwrite = w; in_tnew = t;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_q(input string nm, input logic [1:0] eh, es, ef);
      chk({nm, ".hit"},   64'(q_hit),   64'(eh));
      chk({nm, ".stall"}, 64'(q_stall), 64'(es));
      chk({nm, ".fwd"},   64'(q_fwd),   64'(ef));
   endtask

   initial begin
      //                 name        rst stl fls vld data      a3  rw tn    ev ed        ea  ew et
      vecs[0]  = mk("preload",      0,  0,  0,  1, 64'hA1A1, 8,  1, 2,    1, 64'hA1A1, 8,  1, 1);
      vecs[1]  = mk("reset_all",    1,  1,  1,  1, 64'hFFFF, 9,  1, 3,    0, 64'h0,    0,  0, 0);
      vecs[2]  = mk("tnew0_sat",    0,  0,  0,  1, 64'hB2B2, 8,  1, 0,    1, 64'hB2B2, 8,  1, 0);
      vecs[3]  = mk("tnew3",        0,  0,  0,  1, 64'hC3C3, 3,  1, 3,    1, 64'hC3C3, 3,  1, 2);
      vecs[4]  = mk("stall1",       0,  1,  0,  0, 64'hD4D4, 9,  0, 1,    1, 64'hC3C3, 3,  1, 2);
      vecs[5]  = mk("stall2",       0,  1,  0,  1, 64'hE5E5, 11, 1, 0,    1, 64'hC3C3, 3,  1, 2);
      vecs[6]  = mk("stall3",       0,  1,  0,  1, 64'hF6F6, 10, 1, 2,    1, 64'hC3C3, 3,  1, 2);
      vecs[7]  = mk("unstall",      0,  0,  0,  1, 64'hF6F6, 10, 1, 2,    1, 64'hF6F6, 10, 1, 1);
      vecs[8]  = mk("flush_stall",  0,  1,  1,  1, 64'h1234, 4,  1, 1,    0, 64'h0,    0,  0, 0);
      vecs[9]  = mk("load_g",       0,  0,  0,  1, 64'h7777, 4,  1, 1,    1, 64'h7777, 4,  1, 0);
      vecs[10] = mk("flush_only",   0,  0,  1,  1, 64'h8888, 4,  1, 2,    0, 64'h0,    0,  0, 0);
      vecs[11] = mk("a3_zero",      0,  0,  0,  1, 64'h9999, 0,  1, 1,    1, 64'h9999, 0,  0, 0);
      vecs[12] = mk("invalid_rw",   0,  0,  0,  0, 64'hAAAA, 7,  1, 2,    0, 64'hAAAA, 7,  0, 1);
      vecs[13] = mk("rw_off",       0,  0,  0,  1, 64'hBBBB, 7,  0, 3,    1, 64'hBBBB, 7,  0, 2);
      vecs[14] = mk("reset_mid",    1,  0,  0,  1, 64'hCCCC, 6,  1, 3,    0, 64'h0,    0,  0, 0);

      drive(0, 0, 0, 0, 64'h0, 5'd0, 0, 2'd0);
      q_addr = 10'd0;
      q_tuse = 4'd0;

      // Contents before any clock edge come from the declaration initialisers.
      #1;
      chk("init.valid", 64'(out_valid), 64'd0);
      chk("init.data",  out_data,       64'd0);
      chk("init.tnew",  64'(out_tnew),  64'd0);

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].vld,
               vecs[i].data, vecs[i].a3, vecs[i].rw, vecs[i].tnew);
         tick();
         chk({vecs[i].name, ".valid"}, 64'(out_valid),    64'(vecs[i].e_vld));
         chk({vecs[i].name, ".data"},  out_data,          vecs[i].e_data);
         chk({vecs[i].name, ".a3"},    64'(out_a3),       64'(vecs[i].e_a3));
         chk({vecs[i].name, ".rw"},    64'(out_regwrite), 64'(vecs[i].e_rw));
         chk({vecs[i].name, ".tnew"},  64'(out_tnew),     64'(vecs[i].e_tnew));
      end

      // Hazard: stage holds a3=5, tnew=1. Channel 0 tuse=0, channel 1 tuse=1.
      drive(0, 0, 0, 1, 64'h55, 5'd5, 1, 2'd2);
      tick();
      q_addr = {5'd5, 5'd5};
      q_tuse = {2'd1, 2'd0};
      #1;
      chk_q("hz_tnew1", 2'b11, 2'b01, 2'b00);

      // Only channel 0 asks for r5.
      q_addr = {5'd6, 5'd5};
      #1;
      chk_q("hz_mixaddr", 2'b01, 2'b01, 2'b00);

      // Result now ready in this stage: forward, no stall.
      q_addr = {5'd5, 5'd5};
      drive(0, 0, 0, 1, 64'h56, 5'd5, 1, 2'd1);
      tick();
      chk_q("hz_tnew0", 2'b11, 2'b00, 2'b11);

      // tnew=2 in stage: stalls consumers with tuse 0 and 1.
      drive(0, 0, 0, 1, 64'h57, 5'd5, 1, 2'd3);
      tick();
      chk_q("hz_tnew2", 2'b11, 2'b11, 2'b00);

      // Invalid producer never hits, even with matching a3.
      drive(0, 0, 0, 0, 64'h58, 5'd5, 1, 2'd1);
      tick();
      chk_q("hz_invalid", 2'b00, 2'b00, 2'b00);

      // Reset clears a matching producer.
      drive(0, 0, 0, 1, 64'h59, 5'd5, 1, 2'd1);
      tick();
      chk_q("hz_prereset", 2'b11, 2'b00, 2'b11);
      drive(1, 0, 0, 1, 64'h59, 5'd5, 1, 2'd1);
      tick();
      chk_q("hz_reset", 2'b00, 2'b00, 2'b00);

      // $0 filter: a write to r0 never produces a hit on either channel.
      drive(0, 0, 0, 1, 64'h60, 5'd0, 1, 2'd1);
      q_addr = {5'd0, 5'd0};
      q_tuse = {2'd0, 2'd0};
      tick();
      chk("zero.rw", 64'(out_regwrite), 64'd0);
      chk_q("zero_q", 2'b00, 2'b00, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
